// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the gcd_engine block
//
// Contents:
//   GCD_WIDTH   default operand/result width in bits
//   gcd_state_e control FSM state encoding
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - A/B operand registers, subtractor and compare flags
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears A and B)
//   a_ld, b_ld    load enables for registers A and B
//   use_bus       1: registers load from data_in, 0: from the subtractor
//   data_in       operand bus
//   a_val, b_val  current register contents
//   a_gt_b, a_lt_b, a_eq_b, a_zero, b_zero   compare/status flags
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_ld,
  input  logic             b_ld,
  input  logic             use_bus,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] a_val,
  output logic [WIDTH-1:0] b_val,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_zero,
  output logic             b_zero
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  always_comb begin
    a_gt_b = (a_q > b_q);
    a_lt_b = (a_q < b_q);
    a_eq_b = (a_q == b_q);
    a_zero = (a_q == '0);
    b_zero = (b_q == '0);
  end

  // One subtractor, always larger minus smaller, so it never wraps.
  // When A is zero this yields B unchanged, which is exactly the A <= B
  // move needed for the zero-operand termination case.
  always_comb begin
    diff = a_gt_b ? (a_q - b_q) : (b_q - a_q);
  end

  always_comb begin
    a_next = use_bus ? data_in : diff;
    b_next = use_bus ? data_in : diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_ld) a_q <= a_next;
      if (b_ld) b_q <= b_next;
    end
  end

  assign a_val = a_q;
  assign b_val = b_q;

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - iterative subtract-based GCD unit with serial operand load
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    level request, sampled in IDLE and DONE only
//   data_in  operand bus: A in the LOAD_A cycle, B in the LOAD_B cycle
//   busy     high in LOAD_A, LOAD_B and CALC
//   done     high in DONE; result valid while high
//   result   current contents of register A (the GCD in DONE)
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_LOAD_A = S_LOAD_A;
  localparam logic [2:0] ST_LOAD_B = S_LOAD_B;
  localparam logic [2:0] ST_CALC   = S_CALC;
  localparam logic [2:0] ST_DONE   = S_DONE;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic             a_ld;
  logic             b_ld;
  logic             use_bus;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_zero;
  logic             b_zero;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .a_ld    (a_ld),
    .b_ld    (b_ld),
    .use_bus (use_bus),
    .data_in (data_in),
    .a_val   (a_val),
    .b_val   (b_val),
    .a_gt_b  (a_gt_b),
    .a_lt_b  (a_lt_b),
    .a_eq_b  (a_eq_b),
    .a_zero  (a_zero),
    .b_zero  (b_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    a_ld       = 1'b0;
    b_ld       = 1'b0;
    use_bus    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        a_ld       = 1'b1;
        use_bus    = 1'b1;
        state_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        b_ld       = 1'b1;
        use_bus    = 1'b1;
        state_next = ST_CALC;
      end
      ST_CALC: begin
        // Termination checks first; b_zero also covers gcd(0,0)=0.
        if (b_zero) begin
          state_next = ST_DONE;
        end else if (a_zero) begin
          a_ld       = 1'b1;   // subtractor output is B here
          state_next = ST_DONE;
        end else if (a_eq_b) begin
          state_next = ST_DONE;
        end else if (a_gt_b) begin
          a_ld = 1'b1;
        end else if (a_lt_b) begin
          b_ld = 1'b1;
        end
      end
      ST_DONE: begin
        if (!start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  assign busy   = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_CALC);
  assign done   = (state == ST_DONE);
  assign result = a_val;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - self-checking bench for gcd_engine
module tb_gcd_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int tests_run;
  int tests_failed;

  gcd_engine #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: GCD by Euclid's division; subtraction count is the sum of
  // the Euclid quotients minus one (the last quotient ends at A==B).
  function automatic void model(input int a, input int b, output int g, output int s);
    int x, y, t;
    s = 0;
    if (a == 0 || b == 0) begin
      g = (b == 0) ? a : b;
      return;
    end
    x = a;
    y = b;
    while (y != 0) begin
      s = s + x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    s = s - 1;
  endfunction

  // Runs one computation from IDLE, checks latency/result, then returns to IDLE.
  task automatic run_gcd(input int a, input int b, input bit toggle_start);
    int g, s, cnt;
    model(a, b, g, s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("busy_load_a", busy, 1);
    data_in = a[15:0];
    @(posedge clk); #1;
    chk("busy_load_b", busy, 1);
    data_in = b[15:0];
    @(posedge clk); #1;
    data_in = 16'($urandom);
    cnt = 0;
    while (cnt < s + 10) begin
      if (done) break;
      @(posedge clk); #1;
      cnt++;
      if (toggle_start) start = 1'($urandom);
    end
    start = 1'b1;
    chk("done_latency", cnt, s + 1);
    chk("done_flag", done, 1);
    chk("busy_at_done", busy, 0);
    chk("result", result, g);
    repeat (2) @(posedge clk);
    #1;
    chk("done_hold", done, 1);
    chk("result_hold", result, g);
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    run_gcd(143, 78, 1'b0);
    run_gcd(25, 25, 1'b0);
    run_gcd(0, 36, 1'b0);
    run_gcd(36, 0, 1'b0);
    run_gcd(0, 0, 1'b0);
    run_gcd(17, 5, 1'b0);
    run_gcd(48, 18, 1'b0);
    run_gcd(143, 78, 1'b1);

    // Reset in the middle of CALC must clear outputs without a clock edge.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    data_in = 16'd143;
    @(posedge clk); #1;
    data_in = 16'd78;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_calc_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_done", done, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_result", result, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_done", done, 0);

    for (int i = 0; i < 24; i++) begin
      int ra, rb;
      ra = $urandom_range(255, 0);
      rb = $urandom_range(255, 0);
      run_gcd(ra, rb, 1'($urandom));
    end

    run_gcd(65535, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
